// File: rtl/led_pwm_fader_pkg.sv
// Shared constants and types for the LED PWM fader (optional LED_GAMMA_EN build).
// Defaults target a ~0.5 s full-scale fade at 50 MHz with 8-bit duty.
package led_pkg;

    localparam int unsigned PWM_BITS_DFLT = 8;
    localparam int unsigned DUTY_MAX_DFLT = (1 << PWM_BITS_DFLT) - 1;
    localparam int unsigned CLK_HZ        = 50_000_000;
    // Two full ramps' worth of steps per second gives a ~0.5 s full fade.
    localparam int unsigned FADE_DIV_DFLT = CLK_HZ / (2 * DUTY_MAX_DFLT);

    typedef logic [PWM_BITS_DFLT-1:0] duty_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_fader_if.sv
// Pattern-in / pin-drive bundle between the LED pattern register and the fader.
interface led_pwm_fader_if #(
    parameter int unsigned N_LEDS = 8
);
    logic [N_LEDS-1:0] led_in;
    logic              enable;
    logic [N_LEDS-1:0] led_out;
    logic              fade_busy;
    logic              frame_start;

    modport master (output led_in, enable, input led_out, fade_busy, frame_start);
    modport slave  (input led_in, enable, output led_out, fade_busy, frame_start);
endinterface

// File: rtl/led_pwm_fader_fade_channel.sv
// One LED channel: linear duty ramp toward on/off target, frame-latched duty, registered pin.
// LED_GAMMA_EN squares the frame duty before the PWM compare.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_i,
    input  logic                frame_wrap_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    input  logic                enable_i,
    input  logic                led_i,
    output logic                led_o,
    output logic                busy_o
);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] active_q;
    logic [PWM_BITS-1:0] level;
    logic                led_q;

    assign target = led_i ? DUTY_MAX : '0;

    // Target is always an end stop, so stepping toward it can never wrap.
    always_comb begin
        duty_d = duty_q;
        if (step_i) begin
            if (duty_q < target)      duty_d = duty_q + 1'b1;
            else if (duty_q > target) duty_d = duty_q - 1'b1;
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] active_w;
    logic [2*PWM_BITS-1:0] square;
    assign active_w = {{PWM_BITS{1'b0}}, active_q};
    assign square   = active_w * active_w;
    assign level    = square[2*PWM_BITS-1:PWM_BITS];
`else
    assign level = active_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            active_q <= '0;
            led_q    <= 1'b0;
        end else begin
            duty_q <= duty_d;
            if (frame_wrap_i) active_q <= duty_q;
            led_q <= enable_i & ((active_q == DUTY_MAX) | (pwm_cnt_i < level));
        end
    end

    assign led_o  = led_q;
    assign busy_o = (duty_q != target);

endmodule

// File: rtl/led_pwm_fader.sv
// LED PWM fader top: fade prescaler, shared PWM frame counter, per-LED fade channels.
// Build option LED_GAMMA_EN (see led_fade_channel) selects gamma-corrected brightness.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned PWM_BITS = PWM_BITS_DFLT,
    parameter int unsigned FADE_DIV = FADE_DIV_DFLT
) (
    input logic           clk,
    input logic           rst,
    led_pwm_fader_if.slave bus
);
    localparam int unsigned     PS_W    = cnt_width(FADE_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(FADE_DIV - 1);

    logic [PS_W-1:0]     presc_q, presc_d;
    logic                step;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                frame_wrap;
    logic [N_LEDS-1:0]   busy_vec;
    logic [N_LEDS-1:0]   led_vec;
    logic                fade_busy_q;
    logic                frame_start_q;

    assign step       = (presc_q == PS_LAST);
    assign presc_d    = step ? '0 : presc_q + 1'b1;
    assign frame_wrap = (pwm_cnt_q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            pwm_cnt_q     <= '0;
            fade_busy_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            pwm_cnt_q     <= pwm_cnt_q + 1'b1;
            fade_busy_q   <= |busy_vec;
            frame_start_q <= (pwm_cnt_q == '0);
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .step_i      (step),
            .frame_wrap_i(frame_wrap),
            .pwm_cnt_i   (pwm_cnt_q),
            .enable_i    (bus.enable),
            .led_i       (bus.led_in[i]),
            .led_o       (led_vec[i]),
            .busy_o      (busy_vec[i])
        );
    end

    assign bus.led_out     = led_vec;
    assign bus.fade_busy   = fade_busy_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at PWM_BITS=4, FADE_DIV=3 (expectations adapt to LED_GAMMA_EN).
`timescale 1ns/100ps
module tb_led_pwm_fader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_pwm_fader_if #(.N_LEDS(8)) bus ();

    led_pwm_fader #(
        .N_LEDS  (8),
        .PWM_BITS(4),
        .FADE_DIV(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

`ifdef LED_GAMMA_EN
    localparam logic [7:0]  E21 = 8'h00;
    localparam logic [7:0]  E42 = 8'h00;
    localparam logic [15:0] M2  = 16'h000F;
    localparam logic [15:0] M3  = 16'h0000;
    localparam logic [7:0]  R21 = 8'h00;
`else
    localparam logic [7:0]  E21 = 8'h01;
    localparam logic [7:0]  E42 = 8'h01;
    localparam logic [15:0] M2  = 16'h00FF;
    localparam logic [15:0] M3  = 16'h0007;
    localparam logic [7:0]  R21 = 8'hFF;
`endif

    typedef struct {
        int         k;
        logic [7:0] led_in;
        logic       en;
        logic [7:0] out;
        logic       busy;
        logic       fs;
    } vec_t;

    vec_t        tbl [17];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          ecnt  = 0;
    logic [15:0] pat [5];
    logic [6:0]  others;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] o, input logic b, input logic f);
        check({tag, ".led_out"},     {8'h00, bus.led_out},       {8'h00, o});
        check({tag, ".fade_busy"},   {15'h0, bus.fade_busy},     {15'h0, b});
        check({tag, ".frame_start"}, {15'h0, bus.frame_start},   {15'h0, f});
    endtask

    task automatic run_to(input int k);
        while (ecnt < k) begin
            @(posedge clk);
            ecnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        // {edge after release, led_in, enable, led_out, fade_busy, frame_start}
        tbl[0]  = '{1,  8'h01, 1'b1, 8'h00, 1'b1, 1'b1};
        tbl[1]  = '{2,  8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{16, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{17, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1};
        tbl[4]  = '{21, 8'h01, 1'b1, E21,   1'b1, 1'b0};
        tbl[5]  = '{22, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{33, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1};
        tbl[7]  = '{34, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{35, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[9]  = '{42, 8'h01, 1'b1, E42,   1'b1, 1'b0};
        tbl[10] = '{43, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[11] = '{45, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[12] = '{46, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{49, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1};
        tbl[14] = '{56, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[15] = '{64, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[16] = '{65, 8'h01, 1'b1, 8'h01, 1'b0, 1'b1};

        rst        = 1'b1;
        bus.led_in = 8'hFF;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("reset_hold", 8'h00, 1'b0, 1'b0);

        bus.led_in = 8'h01;
        rst        = 1'b0;
        ecnt       = 0;
        for (int i = 0; i < 17; i++) begin
            bus.led_in = tbl[i].led_in;
            bus.enable = tbl[i].en;
            run_to(tbl[i].k);
            check_outs($sformatf("vec%0d_e%0d", i, tbl[i].k), tbl[i].out, tbl[i].busy, tbl[i].fs);
        end

        // Short async reset pulse between edges while the pin and frame pulse are high.
        #1 rst = 1'b1;
        #0.5 check_outs("arst1_during", 8'h00, 1'b0, 1'b0);
        #0.5 rst = 1'b0;
        bus.led_in = 8'h80;
        #1 check_outs("arst1_after", 8'h00, 1'b0, 1'b0);
        ecnt = 0;

        // Reversal on channel 7 at duty 9; frame-latched duty then reads 8, 3, 0.
        for (int f = 0; f < 5; f++) pat[f] = '0;
        others = '0;
        run_to(27);
        bus.led_in = 8'h00;
        for (int e = 28; e <= 80; e++) begin
            int f;
            int b;
            run_to(e);
            f = (e - 1) / 16;
            b = (e - 1) % 16;
            pat[f][b] = bus.led_out[7];
            others    = others | bus.led_out[6:0];
            if (e == 54) check("rev_busy_e54", {15'h0, bus.fade_busy}, 16'h0001);
            if (e == 55) check("rev_busy_e55", {15'h0, bus.fade_busy}, 16'h0000);
        end
        check("rev_frame2", pat[2], M2);
        check("rev_frame3", pat[3], M3);
        check("rev_frame4", pat[4], 16'h0000);
        check("rev_other_pins", {9'h0, others}, 16'h0000);

        // Reset mid-fade with fade_busy high, then fades restart from duty 0.
        bus.led_in = 8'hFF;
        run_to(84);
        check("busy_before_arst2", {15'h0, bus.fade_busy}, 16'h0001);
        #1 rst = 1'b1;
        #0.5 check_outs("arst2_during", 8'h00, 1'b0, 1'b0);
        #0.5 rst = 1'b0;
        #1 check_outs("arst2_after", 8'h00, 1'b0, 1'b0);
        ecnt = 0;
        run_to(17);
        check("restart_e17_fs", {15'h0, bus.frame_start}, 16'h0001);
        run_to(21);
        check("restart_e21", {8'h00, bus.led_out}, {8'h00, R21});
        run_to(22);
        check("restart_e22", {8'h00, bus.led_out}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
